// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: phase codes to the compression core, block
// geometry and the message-scheduler FSM state type.
package sha256_pkg;

  localparam logic [1:0] PH_INIT  = 2'b00;
  localparam logic [1:0] PH_ROUND = 2'b01;
  localparam logic [1:0] PH_LAST  = 2'b10;
  localparam logic [1:0] PH_SEND  = 2'b11;

  localparam int ROUNDS       = 64;
  localparam int BLOCK_WORDS  = 16;
  localparam int DIGEST_WORDS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ROUND = 3'd2,
    LAST  = 3'd3,
    SEND  = 3'd4
  } sched_state_t;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/msg_scheduler_if.sv
// Word-stream input and core-facing round/word outputs of the message scheduler.
interface msg_scheduler_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic                  start_out;
  logic [1:0]            state_out;
  logic [5:0]            round_out;
  logic [DATA_WIDTH-1:0] w_out;
  logic                  busy;
  logic                  done;

  modport master (
    output s_data, s_valid,
    input  s_ready, start_out, state_out, round_out, w_out, busy, done
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, start_out, state_out, round_out, w_out, busy, done
  );
endinterface

// File: rtl/msg_sigma.sv
// SHA-256 small sigma functions sigma0 and sigma1 of one 32-bit word.
module msg_sigma (
  input  logic [31:0] x,
  output logic [31:0] sig0,
  output logic [31:0] sig1
);
  assign sig0 = {x[6:0],  x[31:7]}  ^ {x[17:0], x[31:18]} ^ {3'b0,  x[31:3]};
  assign sig1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
endmodule

// File: rtl/msg_scheduler.sv
// SHA-256 message schedule generator: loads 16 words, then streams W_0..W_63
// with round/phase codes to the compression core. MSG_SCHED_BSWAP_EN byte-swaps input words.
module msg_scheduler
  import sha256_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  msg_scheduler_if.slave  bus
);

  sched_state_t          state;
  logic [DATA_WIDTH-1:0] win [16];
  logic [3:0]            load_cnt;
  logic [2:0]            send_cnt;
  logic [5:0]            rnd;

  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] sig0_w1, sig1_unused_w1, sig0_unused_w14, sig1_w14;
  logic [DATA_WIDTH-1:0] new_word, shift_word;
  logic                  shift_en;

`ifdef MSG_SCHED_BSWAP_EN
  assign data_in = bswap32(bus.s_data);
`else
  assign data_in = bus.s_data;
`endif

  msg_sigma u_sigma_lo (.x(win[1]),  .sig0(sig0_w1),         .sig1(sig1_unused_w1));
  msg_sigma u_sigma_hi (.x(win[14]), .sig0(sig0_unused_w14), .sig1(sig1_w14));

  assign new_word = sig1_w14 + win[9] + sig0_w1 + win[0];

  always_comb begin
    shift_en   = 1'b0;
    shift_word = data_in;
    if (state == IDLE && bus.s_valid) begin
      shift_en = 1'b1;
    end else if (state == ROUND) begin
      shift_en   = 1'b1;
      shift_word = new_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= shift_word;
    end
  end

  // Control FSM: the window only advances while loading or expanding rounds 0..62.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      load_cnt <= '0;
      send_cnt <= '0;
      rnd      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.s_valid) begin
            load_cnt <= load_cnt + 4'd1;
            if (load_cnt == 4'd15) state <= START;
          end
        end
        START: begin
          rnd   <= '0;
          state <= ROUND;
        end
        ROUND: begin
          rnd <= rnd + 6'd1;
          if (rnd == 6'd62) state <= LAST;
        end
        LAST: begin
          send_cnt <= '0;
          state    <= SEND;
        end
        SEND: begin
          send_cnt <= send_cnt + 3'd1;
          if (send_cnt == 3'd7) begin
            rnd   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (state)
      ROUND:   bus.state_out = PH_ROUND;
      LAST:    bus.state_out = PH_LAST;
      SEND:    bus.state_out = PH_SEND;
      default: bus.state_out = PH_INIT;
    endcase
  end

  assign bus.s_ready   = (state == IDLE);
  assign bus.start_out = (state == START);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == SEND) && (send_cnt == 3'd7);
  assign bus.round_out = rnd;
  assign bus.w_out     = (state == ROUND || state == LAST) ? win[0] : '0;

endmodule

// File: tb/tb_msg_scheduler.sv
// Self-checking bench for msg_scheduler: randomized word streams checked against
// a FIPS 180-4 schedule model and a cycle-offset phase model.
module tb_msg_scheduler;
  import sha256_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  msg_scheduler_if #(.DATA_WIDTH(32)) bus ();

  msg_scheduler #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] words [64];
  logic [31:0] blk   [16];
  logic [31:0] wexp  [64];
  logic [31:0] obs_w [64];
  int n_start, n_round, n_last, n_send, n_done;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] swap_bytes(input logic [31:0] x);
    return ((x & 32'h000000ff) << 24) | ((x & 32'h0000ff00) << 8) |
           ((x & 32'h00ff0000) >> 8)  | ((x & 32'hff000000) >> 24);
  endfunction

  // Word as the scheduler should store it.
  function automatic logic [31:0] stored(input logic [31:0] x);
`ifdef MSG_SCHED_BSWAP_EN
    return swap_bytes(x);
`else
    return x;
`endif
  endfunction

  // Word a host must present so that x gets stored.
  function automatic logic [31:0] host(input logic [31:0] x);
`ifdef MSG_SCHED_BSWAP_EN
    return swap_bytes(x);
`else
    return x;
`endif
  endfunction

  task automatic build_schedule();
    for (int t = 0; t < 16; t++) wexp[t] = blk[t];
    for (int t = 16; t < 64; t++)
      wexp[t] = ssig1(wexp[t-2]) + wexp[t-7] + ssig0(wexp[t-15]) + wexp[t-16];
  endtask

  task automatic load_abc();
    for (int i = 0; i < 64; i++) words[i] = 32'h0;
    words[0]  = host(32'h61626380);
    words[15] = host(32'h00000018);
  endtask

  // Streams nwords words (mode 0: valid held, 1: toggling, 2: random gaps) and
  // checks every output each cycle. ph counts cycles since the 16th accept edge.
  task automatic run_words(input int nwords, input int mode, input int abort_round);
    int idx = 0, cnt = 0, ph = 0, cyc = 0, t;
    logic v;
    logic       e_ready, e_busy, e_start, e_done;
    logic [1:0] e_state;
    logic [5:0] e_round;
    logic [31:0] e_w;
    n_start = 0; n_round = 0; n_last = 0; n_send = 0; n_done = 0;
    for (int i = 0; i < 64; i++) obs_w[i] = 32'hx;
    bus.s_valid = 1'b0;
    while (!(idx >= nwords && ph == 0 && cnt == 0)) begin
      if (cyc >= 3000) begin
        checks++; errors++;
        $display("FAIL run_timeout: got idx=%0d ph=%0d, required all %0d words and idle", idx, ph, nwords);
        break;
      end
      @(negedge clk);
      cyc++;
      e_ready = (ph == 0);
      e_busy  = (ph != 0);
      e_start = (ph == 1);
      e_done  = (ph == 73);
      if (ph <= 1) begin
        e_state = PH_INIT;  e_round = 6'd0;  e_w = 32'h0;
      end else if (ph <= 64) begin
        t = ph - 2;
        e_state = PH_ROUND; e_round = 6'(t); e_w = wexp[t];
      end else if (ph == 65) begin
        e_state = PH_LAST;  e_round = 6'd63; e_w = wexp[63];
      end else begin
        e_state = PH_SEND;  e_round = 6'd63; e_w = 32'h0;
      end
      checks += 7;
      if (bus.s_ready !== e_ready) begin errors++; $display("FAIL s_ready ph=%0d: got %b required %b", ph, bus.s_ready, e_ready); end
      if (bus.busy !== e_busy) begin errors++; $display("FAIL busy ph=%0d: got %b required %b", ph, bus.busy, e_busy); end
      if (bus.start_out !== e_start) begin errors++; $display("FAIL start_out ph=%0d: got %b required %b", ph, bus.start_out, e_start); end
      if (bus.done !== e_done) begin errors++; $display("FAIL done ph=%0d: got %b required %b", ph, bus.done, e_done); end
      if (bus.state_out !== e_state) begin errors++; $display("FAIL state_out ph=%0d: got %b required %b", ph, bus.state_out, e_state); end
      if (bus.round_out !== e_round) begin errors++; $display("FAIL round_out ph=%0d: got %0d required %0d", ph, bus.round_out, e_round); end
      if (bus.w_out !== e_w) begin errors++; $display("FAIL w_out ph=%0d: got %h required %h", ph, bus.w_out, e_w); end
      if (ph >= 2 && ph <= 65) obs_w[ph-2] = bus.w_out;
      if (bus.start_out === 1'b1) n_start++;
      if (bus.state_out === PH_ROUND) n_round++;
      if (bus.state_out === PH_LAST) n_last++;
      if (bus.state_out === PH_SEND) n_send++;
      if (bus.done === 1'b1) n_done++;

      if (abort_round >= 0 && ph == 2 + abort_round) begin
        #2 rst = 1'b1;
        #1;
        checks += 7;
        if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL abort_s_ready: got %b required 1", bus.s_ready); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", bus.busy); end
        if (bus.start_out !== 1'b0) begin errors++; $display("FAIL abort_start_out: got %b required 0", bus.start_out); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b required 0", bus.done); end
        if (bus.state_out !== PH_INIT) begin errors++; $display("FAIL abort_state_out: got %b required 00", bus.state_out); end
        if (bus.round_out !== 6'd0) begin errors++; $display("FAIL abort_round_out: got %0d required 0", bus.round_out); end
        if (bus.w_out !== 32'h0) begin errors++; $display("FAIL abort_w_out: got %h required 0", bus.w_out); end
        bus.s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end

      if (idx >= nwords) v = 1'b0;
      else if (mode == 0) v = 1'b1;
      else if (mode == 1) v = (cyc % 2 == 0);
      else v = ($urandom_range(0, 2) != 0);
      bus.s_valid = v;
      bus.s_data  = (idx < nwords) ? words[idx] : $urandom;
      @(posedge clk);
      if (ph == 0) begin
        if (v) begin
          blk[cnt] = stored(words[idx]);
          idx++;
          cnt++;
          if (cnt == 16) begin
            build_schedule();
            cnt = 0;
            ph  = 1;
          end
        end
      end else begin
        ph = (ph == 73) ? 0 : ph + 1;
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hdeadbeef;
    repeat (3) @(negedge clk);
    checks += 7;
    if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b required 1", bus.s_ready); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    if (bus.start_out !== 1'b0) begin errors++; $display("FAIL reset_start_out: got %b required 0", bus.start_out); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", bus.done); end
    if (bus.state_out !== PH_INIT) begin errors++; $display("FAIL reset_state_out: got %b required 00", bus.state_out); end
    if (bus.round_out !== 6'd0) begin errors++; $display("FAIL reset_round_out: got %0d required 0", bus.round_out); end
    if (bus.w_out !== 32'h0) begin errors++; $display("FAIL reset_w_out: got %h required 0", bus.w_out); end
    bus.s_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abc(input int mode);
    load_abc();
    run_words(16, mode, -1);
    checks += 5;
    if (obs_w[0]  !== 32'h61626380) begin errors++; $display("FAIL abc_w0 mode=%0d: got %h required 61626380", mode, obs_w[0]); end
    if (obs_w[15] !== 32'h00000018) begin errors++; $display("FAIL abc_w15 mode=%0d: got %h required 00000018", mode, obs_w[15]); end
    if (obs_w[16] !== 32'h61626380) begin errors++; $display("FAIL abc_w16 mode=%0d: got %h required 61626380", mode, obs_w[16]); end
    if (obs_w[17] !== 32'h000F0000) begin errors++; $display("FAIL abc_w17 mode=%0d: got %h required 000F0000", mode, obs_w[17]); end
    if (obs_w[18] !== 32'h7DA86405) begin errors++; $display("FAIL abc_w18 mode=%0d: got %h required 7DA86405", mode, obs_w[18]); end
  endtask

  task automatic test_phase_sequence();
    for (int i = 0; i < 16; i++) words[i] = $urandom;
    run_words(16, 2, -1);
    checks += 5;
    if (n_start != 1) begin errors++; $display("FAIL seq_start_count: got %0d required 1", n_start); end
    if (n_round != 63) begin errors++; $display("FAIL seq_round_count: got %0d required 63", n_round); end
    if (n_last != 1) begin errors++; $display("FAIL seq_last_count: got %0d required 1", n_last); end
    if (n_send != 8) begin errors++; $display("FAIL seq_send_count: got %0d required 8", n_send); end
    if (n_done != 1) begin errors++; $display("FAIL seq_done_count: got %0d required 1", n_done); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++) words[i] = $urandom;
    run_words(32, 0, -1);
    checks += 2;
    if (n_start != 2) begin errors++; $display("FAIL b2b_start_count: got %0d required 2", n_start); end
    if (n_done != 2) begin errors++; $display("FAIL b2b_done_count: got %0d required 2", n_done); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 16; i++) words[i] = $urandom;
    run_words(16, 0, 30);
    test_abc(0);
  endtask

  task automatic test_bswap();
`ifdef MSG_SCHED_BSWAP_EN
    for (int i = 0; i < 16; i++) words[i] = 32'h0;
    words[0] = 32'h80636261;
    run_words(16, 0, -1);
    checks++;
    if (obs_w[0] !== 32'h61626380) begin errors++; $display("FAIL bswap_w0: got %h required 61626380", obs_w[0]); end
`endif
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 32'h0;
    test_reset();
    test_abc(0);
    test_abc(1);
    test_phase_sequence();
    test_back_to_back();
    test_mid_reset();
    test_abc(2);
    test_bswap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
